// File: rtl/spi_slave_if.sv
// Bus and SPI pin bundle for spi_slave: CPU byte bus plus external SPI pins.
interface spi_slave_if;
    logic       i_addr;
    logic       i_cs;
    logic       i_we;
    logic [7:0] i_dat;
    logic [7:0] o_dat;
    logic       i_sck;
    logic       i_mosi;
    logic       i_ss;
    logic       o_miso;
    logic       o_miso_oe;

    modport slave (
        input  i_addr, i_cs, i_we, i_dat, i_sck, i_mosi, i_ss,
        output o_dat, o_miso, o_miso_oe
    );

    modport master (
        output i_addr, i_cs, i_we, i_dat, i_sck, i_mosi, i_ss,
        input  o_dat, o_miso, o_miso_oe
    );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 MSB-first responder with single-byte RX/TX holding registers
// behind a two-address CPU byte bus (0 = status/ctl, 1 = data).
module spi_slave #(
    parameter logic       SS_ACTIVE = 1'b1,
    parameter logic [7:0] FILL      = 8'hFF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    spi_slave_if.slave  bus
);
    typedef enum logic {IDLE, ACTIVE} state_t;

    // Synchronisers carry no reset so an SS held through reset is seen as already active.
    logic [2:0] sck_q;
    logic [1:0] mosi_q, ss_q;

    always_ff @(posedge i_clk) begin
        sck_q  <= {sck_q[1:0], bus.i_sck};
        mosi_q <= {mosi_q[0], bus.i_mosi};
        ss_q   <= {ss_q[0], bus.i_ss};
    end

    logic sck_rise, sck_fall, ss_act, mosi_s;
    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] & sck_q[2];
    assign ss_act   = (ss_q[1] == SS_ACTIVE);
    assign mosi_s   = mosi_q[1];

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic [7:0] tx_hold_q, tx_hold_d;
    logic       miso_q, miso_d;
    logic       rx_valid_q, rx_valid_d;
    logic       ovr_q, ovr_d;
    logic       tx_empty_q, tx_empty_d;
    logic       armed_q, armed_d;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            shreg_q    <= FILL;
            rx_data_q  <= 8'h00;
            tx_hold_q  <= 8'h00;
            miso_q     <= 1'b1;
            rx_valid_q <= 1'b0;
            ovr_q      <= 1'b0;
            tx_empty_q <= 1'b1;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            rx_data_q  <= rx_data_d;
            tx_hold_q  <= tx_hold_d;
            miso_q     <= miso_d;
            rx_valid_q <= rx_valid_d;
            ovr_q      <= ovr_d;
            tx_empty_q <= tx_empty_d;
            armed_q    <= armed_d;
        end
    end

    logic       wr_ctl, wr_dat, pop;
    logic [7:0] load_byte;
    assign wr_ctl    = bus.i_cs & bus.i_we & ~bus.i_addr;
    assign wr_dat    = bus.i_cs & bus.i_we & bus.i_addr;
    assign pop       = bus.i_cs & ~bus.i_we & bus.i_addr;
    assign load_byte = tx_empty_q ? FILL : tx_hold_q;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        rx_data_d  = rx_data_q;
        tx_hold_d  = tx_hold_q;
        miso_d     = miso_q;
        rx_valid_d = rx_valid_q;
        ovr_d      = ovr_q;
        tx_empty_d = tx_empty_q;
        // A transfer may only start after SS has been seen inactive since reset.
        armed_d    = armed_q | ~ss_act;

        if (pop)                  rx_valid_d = 1'b0;
        if (wr_ctl && bus.i_dat[2]) ovr_d    = 1'b0;

        case (state_q)
            IDLE: begin
                bit_cnt_d = 3'd0;
                if (ss_act && armed_q) begin
                    state_d    = ACTIVE;
                    shreg_d    = load_byte;
                    miso_d     = load_byte[7];
                    tx_empty_d = 1'b1;
                end
            end
            ACTIVE: begin
                if (!ss_act) begin
                    state_d   = IDLE;
                    bit_cnt_d = 3'd0;
                end else if (sck_rise) begin
                    shreg_d   = {shreg_q[6:0], mosi_s};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d  = {shreg_q[6:0], mosi_s};
                        rx_valid_d = 1'b1;
                        if (rx_valid_q && !pop) ovr_d = 1'b1;
                    end
                end else if (sck_fall) begin
                    if (bit_cnt_q != 3'd0) begin
                        miso_d = shreg_q[7];
                    end else begin
                        shreg_d    = load_byte;
                        miso_d     = load_byte[7];
                        tx_empty_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Placed after the load so a same-cycle write leaves tx_empty at 0.
        if (wr_dat) begin
            tx_hold_d  = bus.i_dat;
            tx_empty_d = 1'b0;
        end
    end

    assign bus.o_dat     = bus.i_addr ? rx_data_q
                                      : {ss_act, 4'b0000, ovr_q, tx_empty_q, rx_valid_q};
    assign bus.o_miso    = miso_q;
    assign bus.o_miso_oe = (state_q == ACTIVE);
endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: byte-level register model plus directed and random frames.
module tb_spi_slave;
    localparam logic SS_ON = 1'b1;

    logic i_clk = 1'b0;
    logic i_reset;
    always #5 i_clk = ~i_clk;

    spi_slave_if bus();

    spi_slave #(.SS_ACTIVE(SS_ON), .FILL(8'hFF)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int half    = 4;
    bit chk_en  = 1'b0;

    // Byte-level model of the register file.
    logic [7:0] m_hold, m_rx;
    logic       m_txe, m_rxv, m_ovr, m_busy, m_sel;
    logic [7:0] f_mo[4], f_mi[4], f_exp[4];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_status();
        return {m_busy, 4'b0000, m_ovr, m_txe, m_rxv};
    endfunction

    always @(negedge i_clk) begin
        if (chk_en) begin
            chk("o_dat", bus.o_dat, bus.i_addr ? m_rx : m_status());
            chk("miso_oe", bus.o_miso_oe, m_sel);
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic m_reset();
        m_hold = 8'h00; m_rx = 8'h00; m_txe = 1'b1;
        m_rxv = 1'b0; m_ovr = 1'b0; m_sel = 1'b0;
    endtask

    task automatic m_load(output logic [7:0] b);
        b = m_txe ? 8'hFF : m_hold;
        m_txe = 1'b1;
    endtask

    task automatic bus_wr(logic a, logic [7:0] d);
        @(posedge i_clk); #1;
        bus.i_addr = a; bus.i_we = 1'b1; bus.i_dat = d; bus.i_cs = 1'b1;
        @(posedge i_clk); #1;
        bus.i_cs = 1'b0; bus.i_we = 1'b0; bus.i_addr = 1'b0;
        if (a) begin m_hold = d; m_txe = 1'b0; end
        else if (d[2]) m_ovr = 1'b0;
    endtask

    task automatic bus_rd(logic a, output logic [7:0] d);
        @(posedge i_clk); #1;
        bus.i_addr = a; bus.i_we = 1'b0; bus.i_cs = 1'b1;
        @(negedge i_clk);
        d = bus.o_dat;
        @(posedge i_clk); #1;
        bus.i_cs = 1'b0; bus.i_addr = 1'b0;
        if (a) m_rxv = 1'b0;
    endtask

    task automatic sck_bit(logic b, output logic m);
        bus.i_mosi = b;
        tick(half);
        m = bus.o_miso;
        bus.i_sck = 1'b1;
        tick(half);
        bus.i_sck = 1'b0;
    endtask

    task automatic ss_off();
        chk_en = 1'b0;
        bus.i_ss = ~SS_ON;
        tick(6);
        m_busy = 1'b0; m_sel = 1'b0;
        chk_en = 1'b1;
    endtask

    task automatic frame(int nb, bit mid_wr, logic [7:0] mid_val, bit hold);
        logic [7:0] cur;
        logic m;
        chk_en = 1'b0;
        bus.i_ss = SS_ON;
        tick(6);
        m_busy = 1'b1; m_sel = 1'b1;
        m_load(cur);
        for (int k = 0; k < nb; k++) begin
            f_exp[k] = cur;
            for (int i = 7; i >= 0; i--) begin
                sck_bit(f_mo[k][i], m);
                f_mi[k][i] = m;
                if (k == 0 && i == 4 && mid_wr) bus_wr(1'b1, mid_val);
            end
            if (m_rxv) m_ovr = 1'b1;
            m_rxv = 1'b1;
            m_rx  = f_mo[k];
            m_load(cur);
            chk("miso_byte", f_mi[k], f_exp[k]);
        end
        tick(4);
        if (hold) chk_en = 1'b1;
        else ss_off();
    endtask

    initial begin
        logic [7:0] d;
        logic m;
        bus.i_addr = 1'b0; bus.i_cs = 1'b0; bus.i_we = 1'b0; bus.i_dat = 8'h00;
        bus.i_sck = 1'b0; bus.i_mosi = 1'b0; bus.i_ss = ~SS_ON;
        i_reset = 1'b1;
        m_reset(); m_busy = 1'b0;
        tick(4);
        i_reset = 1'b0;
        chk_en = 1'b1;
        tick(1);

        // Reset state
        bus_rd(1'b0, d);
        chk("rst_status", d, 8'h02);
        chk("rst_oe", bus.o_miso_oe, 1'b0);
        chk("rst_miso", bus.o_miso, 1'b1);

        // Basic byte with held SS
        bus_wr(1'b1, 8'hA5);
        f_mo[0] = 8'h3C;
        frame(1, 1'b0, 8'h00, 1'b1);
        chk("a5_miso", f_mi[0], 8'hA5);
        bus_rd(1'b0, d);
        chk("held_status", d, 8'h83);
        bus_rd(1'b1, d);
        chk("rx_3c", d, 8'h3C);
        bus_rd(1'b0, d);
        chk("after_pop", d, 8'h82);
        ss_off();

        // Fill byte, then overrun
        f_mo[0] = 8'h00;
        frame(1, 1'b0, 8'h00, 1'b0);
        chk("fill_miso", f_mi[0], 8'hFF);
        f_mo[0] = 8'h11;
        frame(1, 1'b0, 8'h00, 1'b0);
        bus_rd(1'b0, d);
        chk("ovr_status", d, 8'h07);
        bus_rd(1'b1, d);
        chk("rx_11", d, 8'h11);
        bus_wr(1'b0, 8'h04);
        bus_rd(1'b0, d);
        chk("ovr_clr", d, 8'h02);

        // Two-byte frame with mid-byte refill
        f_mo[0] = 8'hC3; f_mo[1] = 8'h96;
        frame(2, 1'b1, 8'h12, 1'b0);
        chk("refill_b0", f_mi[0], 8'hFF);
        chk("refill_b1", f_mi[1], 8'h12);
        bus_rd(1'b0, d);
        chk("two_status", d, 8'h07);
        bus_rd(1'b1, d);
        chk("rx_96", d, 8'h96);
        bus_wr(1'b0, 8'h04);

        // Partial byte discarded
        chk_en = 1'b0;
        bus.i_ss = SS_ON;
        tick(6);
        m_busy = 1'b1; m_sel = 1'b1;
        m_load(d);
        sck_bit(1'b1, m);
        sck_bit(1'b0, m);
        bus.i_mosi = 1'b1;
        tick(half);
        bus.i_sck = 1'b1;
        tick(half);
        bus.i_ss = ~SS_ON;
        tick(6);
        bus.i_sck = 1'b0;
        tick(6);
        m_busy = 1'b0; m_sel = 1'b0;
        chk_en = 1'b1;
        bus_rd(1'b0, d);
        chk("partial_status", d, 8'h02);
        chk("partial_oe", bus.o_miso_oe, 1'b0);
        bus_wr(1'b1, 8'h81);
        f_mo[0] = 8'hE7;
        frame(1, 1'b0, 8'h00, 1'b0);
        chk("after_partial_miso", f_mi[0], 8'h81);
        bus_rd(1'b1, d);
        chk("rx_e7", d, 8'hE7);

        // Reset at bit 3 with SS held
        bus_wr(1'b1, 8'h3F);
        chk_en = 1'b0;
        bus.i_ss = SS_ON;
        tick(6);
        m_busy = 1'b1; m_sel = 1'b1;
        m_load(d);
        for (int i = 0; i < 3; i++) sck_bit(1'b1, m);
        tick(2);
        i_reset = 1'b1;
        tick(2);
        i_reset = 1'b0;
        m_reset();
        chk_en = 1'b1;
        chk("midrst_oe", bus.o_miso_oe, 1'b0);
        chk("midrst_miso", bus.o_miso, 1'b1);
        bus_rd(1'b0, d);
        chk("midrst_status", d, 8'h82);
        for (int i = 7; i >= 0; i--) begin
            sck_bit(1'b0, m);
            f_mi[0][i] = m;
        end
        chk("midrst_idle_miso", f_mi[0], 8'hFF);
        tick(6);
        ss_off();
        f_mo[0] = 8'h5A;
        frame(1, 1'b0, 8'h00, 1'b0);
        chk("rearm_miso", f_mi[0], 8'hFF);
        bus_rd(1'b1, d);
        chk("rx_5a", d, 8'h5A);

        // Randomized frames
        for (int it = 0; it < 25; it++) begin
            int nb;
            bit mw;
            half = int'($urandom_range(4, 7));
            if ($urandom_range(0, 1) == 1) bus_wr(1'b1, 8'($urandom));
            nb = int'($urandom_range(1, 3));
            for (int k = 0; k < nb; k++) f_mo[k] = 8'($urandom);
            mw = ($urandom_range(0, 2) == 0);
            frame(nb, mw, 8'($urandom), 1'b0);
            if ($urandom_range(0, 1) == 1) begin
                logic [7:0] exp_rx;
                exp_rx = m_rx;
                bus_rd(1'b1, d);
                chk("rand_rx", d, exp_rx);
            end
            if ($urandom_range(0, 2) == 0) bus_wr(1'b0, 8'h04);
        end

        tick(4);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
